// File: rtl/mac_dot_seq_if.sv
// +----------------------------------------------------------------------------+
// | mac_dot_seq_if : operand stream, control and result handshake bundle      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mac_dot_seq_if #(
  parameter int FEAT_BIT   = 16,
  parameter int WEIGHT_BIT = 8,
  parameter int ACC_BIT    = 32,
  parameter int LEN_BIT    = 8
) ();
  logic                  start;
  logic [LEN_BIT-1:0]    len;
  logic                  abort;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [FEAT_BIT-1:0]   in_feat;
  logic [WEIGHT_BIT-1:0] in_weight;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_BIT-1:0]    out_data;

  modport master (
    output start, len, abort, in_valid, in_feat, in_weight, out_ready,
    input  busy, in_ready, out_valid, out_data
  );

  modport slave (
    input  start, len, abort, in_valid, in_feat, in_weight, out_ready,
    output busy, in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/mac_dot_seq.sv
// +----------------------------------------------------------------------------+
// | mac_dot_seq : streams signed feature/weight pairs through a 16x8 multiplier|
// |               and accumulates a programmable-length dot product           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mac_dot_seq #(
  parameter int FEAT_BIT   = 16,
  parameter int WEIGHT_BIT = 8,
  parameter int OUT_BIT    = 32,
  parameter int ACC_BIT    = 32,
  parameter int LEN_BIT    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_dot_seq_if.slave   bus
);

  localparam int PROD_W = FEAT_BIT + WEIGHT_BIT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_BIT-1:0]   remaining_q, remaining_d;
  logic [ACC_BIT-1:0]   acc_q, acc_d;
  logic [OUT_BIT-1:0]   prod_q, prod_d;
  logic                 prod_v_q, prod_v_d;
  logic                 busy_q, busy_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic signed [PROD_W-1:0] prod_full;
  logic [OUT_BIT-1:0]       prod_ext;
  logic [ACC_BIT-1:0]       acc_add;
  logic                     beat;

  assign prod_full = $signed(bus.in_feat) * $signed(bus.in_weight);

  generate
    if (OUT_BIT > PROD_W) begin : g_prod_ext
      assign prod_ext = {{(OUT_BIT-PROD_W){prod_full[PROD_W-1]}}, prod_full};
    end else begin : g_prod_eq
      assign prod_ext = prod_full[OUT_BIT-1:0];
    end
  endgenerate

  generate
    if (ACC_BIT > OUT_BIT) begin : g_acc_ext
      assign acc_add = {{(ACC_BIT-OUT_BIT){prod_q[OUT_BIT-1]}}, prod_q};
    end else begin : g_acc_eq
      assign acc_add = prod_q;
    end
  endgenerate

  assign beat = bus.in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    prod_d      = prod_q;
    prod_v_d    = 1'b0;
    // The registered product lands in the accumulator one edge after capture.
    acc_d       = prod_v_q ? (acc_q + acc_add) : acc_q;

    if (bus.abort) begin
      state_d     = IDLE;
      remaining_d = '0;
      acc_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_d = '0;
            if (bus.len != '0) begin
              state_d     = RUN;
              remaining_d = bus.len;
            end else begin
              state_d = DONE;
            end
          end
        end
        RUN: begin
          if (beat) begin
            prod_d      = prod_ext;
            prod_v_d    = 1'b1;
            remaining_d = remaining_q - LEN_BIT'(1);
            if (remaining_q == LEN_BIT'(1)) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          state_d = DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_dot_seq.sv
// +----------------------------------------------------------------------------+
// | tb_mac_dot_seq : scoreboard bench for the dot-product sequencer           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mac_dot_seq;

  logic clk;
  logic rst_n;

  mac_dot_seq_if bus ();

  mac_dot_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          fa[$];
  int          wb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result monitor: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected: got %0h expected none", bus.out_data);
      end else begin
        chk("result", 64'(bus.out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 50 && bus.busy; k++) tick();
    chk(nm, 64'(bus.busy), 64'd0);
  endtask

  task automatic fill_const(input int n, input int f, input int w);
    fa.delete();
    wb.delete();
    for (int i = 0; i < n; i++) begin
      fa.push_back(f);
      wb.push_back(w);
    end
  endtask

  task automatic fill_rand(input int n);
    fa.delete();
    wb.delete();
    for (int i = 0; i < n; i++) begin
      fa.push_back(int'($urandom_range(0, 65535)) - 32768);
      wb.push_back(int'($urandom_range(0, 255)) - 128);
    end
  endtask

  // gap: 0 back-to-back, 1 alternate valid, 2 random valid. hold: stall result consumer.
  task automatic run_dot(input int n, input int gap, input bit hold);
    logic [63:0] sum;
    int          beats;
    int          cyc;
    bit          v;
    bit          rdy;
    sum           = '0;
    bus.out_ready = !hold;
    bus.start     = 1'b1;
    bus.len       = n[7:0];
    tick();
    bus.start = 1'b0;
    if (n == 0) begin
      exp_q.push_back(32'd0);
      chk("len0_valid", 64'(bus.out_valid), 64'd1);
    end else begin
      beats = 0;
      cyc   = 0;
      while (beats < n && cyc < 4 * n + 50) begin
        case (gap)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        rdy           = bus.in_ready;
        bus.in_valid  = v;
        bus.in_feat   = 16'(fa[beats]);
        bus.in_weight = 8'(wb[beats]);
        tick();
        cyc++;
        if (v && rdy) begin
          sum += 64'(longint'(fa[beats]) * longint'(wb[beats]));
          beats++;
        end
      end
      bus.in_valid = 1'b0;
      chk("beats_accepted", 64'(beats), 64'(n));
      exp_q.push_back(sum[31:0]);
      chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
      chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
      tick();
      chk("done_out_valid", 64'(bus.out_valid), 64'd1);
      chk("done_in_ready", 64'(bus.in_ready), 64'd0);
    end
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        bus.start = 1'b1;
        bus.len   = 8'd7;
        tick();
        chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_out_data", 64'(bus.out_data), 64'(sum[31:0]));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("done_start_idle_only", 64'(bus.busy), 64'd0);
      tick();
      chk("start_not_taken", 64'(bus.in_ready), 64'd0);
    end
    wait_idle("return_idle");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_feat   = '0;
    bus.in_weight = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    fa = '{1, -2, 100};
    wb = '{1, 3, -128};
    run_dot(3, 0, 1'b0);

    fill_const(4, 7, 7);
    run_dot(4, 1, 1'b0);

    run_dot(0, 0, 1'b1);

    fill_const(255, -32768, -128);
    run_dot(255, 0, 1'b0);

    fa = '{5, 4};
    wb = '{-3, 6};
    run_dot(2, 0, 1'b1);

    // Abort mid-run after two beats; nothing is expected from the cancelled job.
    bus.start = 1'b1;
    bus.len   = 8'd5;
    tick();
    bus.start = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_feat   = 16'd9;
    bus.in_weight = 8'd9;
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_acc", 64'(bus.out_data), 64'd0);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.len   = 8'd3;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_start_idle", 64'(bus.busy), 64'd0);
    fa = '{2};
    wb = '{3};
    run_dot(1, 0, 1'b0);

    // Asynchronous reset in the middle of a run.
    bus.start = 1'b1;
    bus.len   = 8'd5;
    tick();
    bus.start = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_feat   = 16'd3;
    bus.in_weight = 8'd4;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_release_busy", 64'(bus.busy), 64'd0);
    fa = '{-6, 11};
    wb = '{5, -2};
    run_dot(2, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = int'($urandom_range(1, 20));
      fill_rand(n);
      run_dot(n, 2, 1'b0);
    end

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
